jtpopeye_bck_arb: RTL and testbench
===================================

Name: jtpopeye_bck_arb

Overview:
- Arbiter and sequencer for the single-port 4K x 8 background RAM. Each RAM byte holds two 4-bit background colour nibbles.
- Shares the RAM between two requesters:
  - CPU nibble writes, done as read-modify-write (RMW) through a small FIFO.
  - Video nibble reads, which have fixed priority and bounded latency.
- Sits between the CPU bus decode, the video fetch logic and a jtgng_ram instance. The RAM instance is external to this block.

Parameters:
- DEPTH, 4, CPU write FIFO entries (power of two, 2..16).
- AW, 12, RAM address width.

Ports:
- clk in 1: system clock.
- rst_n in 1: asynchronous active-low reset.
- CSBW_n in 1: CPU background chip select, active low.
- DWRBK in 1: CPU write strobe. A write is captured on its rising edge.
- cpu_addr in 13: de-obfuscated CPU address. Bit 12 selects the nibble: 0 = low [3:0], 1 = high [7:4].
- cpu_din in 4: CPU write nibble.
- cpu_wait out 1: FIFO full.
- ovf out 1: sticky flag; a write was dropped.
- vid_req in 1: video read request, one-cycle pulse.
- vid_addr in 12: video read address.
- vid_lo in 1: 1 = return [3:0], 0 = return [7:4].
- vid_valid out 1: video data valid, one-cycle pulse.
- vid_data out 4: returned nibble.
- ram_addr out 12: RAM address.
- ram_din out 8: RAM write data.
- ram_we out 1: RAM write enable.
- ram_dout in 8: RAM read data, valid one clk after ram_addr.

Behaviour:
- Reset (async):
  - Outputs: ram_we=0, ram_addr=0, ram_din=0, vid_valid=0, vid_data=0, cpu_wait=0, ovf=0.
  - Internal state: FIFO empty, FSM=IDLE, DWRBK edge register=0, video pipeline cleared.
  - Reset mid-RMW aborts the operation. ram_we deasserts immediately; no partial write occurs.
- Capture:
  - A CPU write is captured when the registered DWRBK was 0, DWRBK is now 1, and CSBW_n=0.
  - Capture pushes {cpu_addr[12:0], cpu_din} into the FIFO.
  - If the FIFO is full on the capture cycle, the entry is dropped and ovf is set. ovf clears only on reset.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - cpu_wait = (count==DEPTH), registered.
- FSM states: IDLE, RD, CAP, WR.
  - IDLE -> RD when the FIFO is non-empty and no video grant this cycle.
  - RD: ram_addr = head address; ram_we=0.
  - CAP: hold the head; ram_dout is valid; form ram_din. Low-nibble entry: {dout[7:4],din}. High-nibble entry: {din,dout[3:0]}.
  - WR: ram_we=1 for exactly one clk, using the same address. Pop the FIFO. Next state is RD if the FIFO is still non-empty after the pop, otherwise IDLE.
- Video priority:
  - A vid_req in IDLE, RD or CAP is granted the same cycle: ram_addr=vid_addr and ram_we=0 on the next edge.
  - An RMW in RD or CAP is preempted and restarts from RD after the video slot. The head is not popped.
  - A vid_req arriving during WR is held one cycle and granted next.
  - Only one request may be pending. A vid_req arriving while one is pending is an illegal stimulus; the bench must not do it.
- Video latency:
  - vid_valid and vid_data appear 2 clk after grant.
  - This gives 2 clk from vid_req normally, and 3 clk if it collided with WR.
  - vid_data = vid_lo ? dout[3:0] : dout[7:4].
  - vid_data holds its value between pulses.
- Coherency: no forwarding. A video read of an address with a pending FIFO entry returns pre-write RAM contents.
- Back-to-back writes to the same byte are ordered. Each RMW completes (WR) before the next RD, so both nibbles land.

Decomposition:
- Package jtpopeye_bck_pkg: FSM state encoding constants, DEPTH default, and the FIFO entry width (17).
- Sub-module jtpopeye_bck_fifo:
  - Synchronous FIFO with count, full and empty.
  - Same-cycle push/pop handling.
  - Async reset.

Test Plan:
- Single low-nibble write: RAM[0x123]=0xA5; CPU writes addr 0x0123 data 0x3 -> after WR, RAM[0x123]=0xA3. ram_we is high for exactly 1 clk, 3 clk after the capture cycle.
- Nibble pair to same byte: write 0x1123 data 0xC, then 0x0123 data 0x4 back-to-back -> RAM[0x123]=0xC4, two WR pulses, ovf=0.
- Video priority: vid_req (addr 0x200, lo=1, RAM=0x7E) during CAP -> vid_valid 2 clk later with vid_data=0xE. RMW restarts at RD and the pending write still lands.
- WR collision: vid_req asserted during WR -> vid_valid 3 clk after vid_req; ram_we pulse intact.
- Overflow: 5 captures with no RMW slots (continuous vid_req, DEPTH=4) -> cpu_wait=1 after the 4th, ovf=1 after the 5th. The first 4 entries are later written in order.
- Reset during WR: rst_n low -> ram_we=0 combinationally, FIFO empty, ovf=0. After release, IDLE with no RAM activity.

Source files
------------

// File: rtl/jtpopeye_bck_pkg.sv
// rtl/jtpopeye_bck_pkg.sv - shared constants, state type and nibble merge for the background RAM arbiter
package jtpopeye_bck_pkg;

    localparam int BCK_DEPTH   = 4;   // CPU write FIFO entries
    localparam int BCK_AW      = 12;  // background RAM address width
    localparam int BCK_ENTRY_W = 17;  // {nibble select, RAM address, write nibble}

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } bck_state_t;

    // Replace one nibble of a RAM byte; i_hi selects bits [7:4].
    function automatic logic [7:0] bck_merge(input logic i_hi, input logic [3:0] i_nib,
                                             input logic [7:0] i_byte);
        return i_hi ? {i_nib, i_byte[3:0]} : {i_byte[7:4], i_nib};
    endfunction

endpackage

// File: rtl/jtpopeye_bck_fifo.sv
// rtl/jtpopeye_bck_fifo.sv - CPU write FIFO with count, registered full and look-ahead head
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_din (ignored while full)
//   i_pop        drop the head entry (ignored while empty)
//   o_head       current head entry
//   o_head_nxt   entry that becomes head once this cycle's pop completes
//   o_count      number of stored entries
//   o_full       registered count==DEPTH
//   o_empty      count==0
module jtpopeye_bck_fifo
    import jtpopeye_bck_pkg::*;
#(
    parameter int DEPTH = BCK_DEPTH,
    parameter int W     = BCK_ENTRY_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic [W-1:0]           o_head_nxt,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_full;

    logic          w_push;
    logic          w_pop;
    logic [PW:0]   w_count_nxt;
    logic [PW-1:0] w_rptr_inc;

    assign w_push     = i_push && !r_full;
    assign w_pop      = i_pop && (r_count != '0);
    assign w_rptr_inc = r_rptr + PW'(1);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= w_rptr_inc;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
        end
    end

    assign o_head     = r_mem[r_rptr];
    // With a single entry left, the next head can only be the one arriving now.
    assign o_head_nxt = (r_count == CNT_ONE) ? i_din : r_mem[w_rptr_inc];
    assign o_count    = r_count;
    assign o_full     = r_full;
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/jtpopeye_bck_arb.sv
// rtl/jtpopeye_bck_arb.sv - background RAM arbiter: CPU nibble RMW writes vs. priority video reads
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   CSBW_n, DWRBK           CPU chip select (active low) and write strobe (rising edge captures)
//   cpu_addr, cpu_din       CPU address (bit 12 = high nibble) and write nibble
//   cpu_wait, ovf           FIFO full, sticky dropped-write flag
//   vid_req, vid_addr,
//   vid_lo                  video read request pulse, address, nibble select (1 = [3:0])
//   vid_valid, vid_data     returned nibble, valid pulse 2 clk after grant
//   ram_addr, ram_din,
//   ram_we, ram_dout        single-port RAM interface, ram_dout valid 1 clk after ram_addr
module jtpopeye_bck_arb
    import jtpopeye_bck_pkg::*;
#(
    parameter int DEPTH = BCK_DEPTH,
    parameter int AW    = BCK_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CSBW_n,
    input  logic          DWRBK,
    input  logic [AW:0]   cpu_addr,
    input  logic [3:0]    cpu_din,
    output logic          cpu_wait,
    output logic          ovf,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          vid_lo,
    output logic          vid_valid,
    output logic [3:0]    vid_data,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    localparam int             EW      = AW + 5;
    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    bck_state_t    r_state;
    bck_state_t    w_state_nxt;

    logic          r_dwrbk;
    logic          r_ovf;
    logic [AW-1:0] r_ram_addr;
    logic [7:0]    r_ram_din;
    logic          r_ram_we;
    logic          r_cur_hi;
    logic [3:0]    r_cur_din;

    logic          r_vpend;
    logic [AW-1:0] r_vpend_addr;
    logic          r_vpend_lo;
    logic          r_vp0;
    logic          r_vp0_lo;
    logic          r_vp1;
    logic          r_vp1_lo;
    logic          r_vid_valid;
    logic [3:0]    r_vid_data;

    logic          w_capture;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_head_nxt;
    logic [EW-1:0] w_rd_entry;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_vreq;
    logic [AW-1:0] w_vaddr;
    logic          w_vlo;
    logic          w_grant;

    assign w_capture = !r_dwrbk && DWRBK && !CSBW_n;
    assign w_push    = w_capture && !w_full;
    assign w_entry   = {cpu_addr, cpu_din};

    jtpopeye_bck_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_din      (w_entry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_head_nxt (w_head_nxt),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // A request that lands on WR is parked and presented again next cycle.
    assign w_vreq  = vid_req || r_vpend;
    assign w_vaddr = r_vpend ? r_vpend_addr : vid_addr;
    assign w_vlo   = r_vpend ? r_vpend_lo   : vid_lo;
    assign w_grant = w_vreq && (r_state != ST_WR);

    // Leaving WR for RD must address the entry behind the one being popped.
    assign w_rd_entry = (r_state == ST_WR) ? w_head_nxt : w_head;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_grant && !w_empty) w_state_nxt = ST_RD;
            ST_RD:   w_state_nxt = w_grant ? ST_IDLE : ST_CAP;
            ST_CAP:  w_state_nxt = w_grant ? ST_IDLE : ST_WR;
            ST_WR: begin
                w_pop       = 1'b1;
                w_state_nxt = ((w_count != CNT_ONE) || w_push) ? ST_RD : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dwrbk      <= 1'b0;
            r_ovf        <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_we     <= 1'b0;
            r_cur_hi     <= 1'b0;
            r_cur_din    <= '0;
            r_vpend      <= 1'b0;
            r_vpend_addr <= '0;
            r_vpend_lo   <= 1'b0;
            r_vp0        <= 1'b0;
            r_vp0_lo     <= 1'b0;
            r_vp1        <= 1'b0;
            r_vp1_lo     <= 1'b0;
            r_vid_valid  <= 1'b0;
            r_vid_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dwrbk <= DWRBK;
            if (w_capture && w_full) r_ovf <= 1'b1;

            if (r_state == ST_WR && vid_req) begin
                r_vpend      <= 1'b1;
                r_vpend_addr <= vid_addr;
                r_vpend_lo   <= vid_lo;
            end else if (w_grant) begin
                r_vpend <= 1'b0;
            end

            // RAM port: the video slot wins over any RMW step.
            r_ram_we <= 1'b0;
            if (w_grant) begin
                r_ram_addr <= w_vaddr;
            end else if (w_state_nxt == ST_RD) begin
                r_ram_addr <= w_rd_entry[EW-2:4];
                r_cur_hi   <= w_rd_entry[EW-1];
                r_cur_din  <= w_rd_entry[3:0];
            end else if (w_state_nxt == ST_WR) begin
                r_ram_we  <= 1'b1;
                r_ram_din <= bck_merge(r_cur_hi, r_cur_din, ram_dout);
            end

            // Grant -> address on RAM -> data out of RAM -> nibble returned.
            r_vp0       <= w_grant;
            r_vp0_lo    <= w_vlo;
            r_vp1       <= r_vp0;
            r_vp1_lo    <= r_vp0_lo;
            r_vid_valid <= r_vp1;
            if (r_vp1) r_vid_data <= r_vp1_lo ? ram_dout[3:0] : ram_dout[7:4];
        end
    end

    assign cpu_wait  = w_full;
    assign ovf       = r_ovf;
    assign vid_valid = r_vid_valid;
    assign vid_data  = r_vid_data;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_we    = r_ram_we;

endmodule

// File: tb/tb_jtpopeye_bck_arb.sv
// tb/tb_jtpopeye_bck_arb.sv - scoreboard bench for the background RAM arbiter
module tb_jtpopeye_bck_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CSBW_n;
    logic        DWRBK;
    logic [12:0] cpu_addr;
    logic [3:0]  cpu_din;
    logic        cpu_wait;
    logic        ovf;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_lo;
    logic        vid_valid;
    logic [3:0]  vid_data;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout = 8'h00;

    logic [7:0]  mem [4096];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct { logic [11:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
    typedef struct { logic [3:0] data; int cyc; } vid_exp_t;
    wr_exp_t  wr_q[$];
    vid_exp_t vid_q[$];

    jtpopeye_bck_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CSBW_n    (CSBW_n),
        .DWRBK     (DWRBK),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_wait  (cpu_wait),
        .ovf       (ovf),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_lo    (vid_lo),
        .vid_valid (vid_valid),
        .vid_data  (vid_data),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_set(input logic [12:0] a, input logic [3:0] d);
        cpu_addr = a;
        cpu_din  = d;
        CSBW_n   = 1'b0;
        DWRBK    = 1'b1;
    endtask

    task automatic cpu_clr();
        CSBW_n = 1'b1;
        DWRBK  = 1'b0;
    endtask

    task automatic exp_wr(input logic [11:0] a, input logic [7:0] d, input int c);
        wr_q.push_back('{a, d, c});
    endtask

    task automatic exp_vid(input logic [3:0] d, input int c);
        vid_q.push_back('{d, c});
    endtask

    // Monitor: every RAM write and every video pulse is matched against the scoreboard.
    initial begin
        logic    prev_we;
        wr_exp_t we;
        vid_exp_t ve;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected_we", 32'(ram_we), 32'd0);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(we.addr));
                    check("wr_data", 32'(ram_din), 32'(we.data));
                    check("wr_width", 32'(prev_we), 32'd0);
                    if (we.cyc >= 0) check("wr_cycle", cyc, we.cyc);
                end
            end
            if (vid_valid) begin
                if (vid_q.size() == 0) begin
                    check("vid_unexpected_valid", 32'(vid_valid), 32'd0);
                end else begin
                    ve = vid_q.pop_front();
                    check("vid_data", 32'(vid_data), 32'(ve.data));
                    check("vid_cycle", cyc, ve.cyc);
                end
            end
            prev_we = ram_we;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n    = 1'b1;
        CSBW_n   = 1'b1;
        DWRBK    = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        vid_req  = 1'b0;
        vid_addr = '0;
        vid_lo   = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h123] = 8'hA5;
        mem[12'h200] = 8'h7E;
        mem[12'h201] = 8'hB4;
        mem[12'h300] = 8'h55;
        mem[12'h400] = 8'h12;
        for (int i = 0; i < 5; i++) mem[12'h500 + i] = 8'hF0;
        mem[12'h600] = 8'h88;

        // Reset state
        #3 rst_n = 1'b0;
        nclk(2);
        check("rst_ram_we",    32'(ram_we),    32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_ram_din",   32'(ram_din),   32'd0);
        check("rst_vid_valid", 32'(vid_valid), 32'd0);
        check("rst_vid_data",  32'(vid_data),  32'd0);
        check("rst_cpu_wait",  32'(cpu_wait),  32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        rst_n = 1'b1;
        nclk(2);

        // Single low-nibble write: 0xA5 -> 0xA3, WR three edges after capture
        c = cyc;
        exp_wr(12'h123, 8'hA3, c + 4);
        cpu_set(13'h0123, 4'h3);
        nclk(1); cpu_clr();
        nclk(10);
        check("t1_ram", 32'(mem[12'h123]), 32'h0A3);

        // Back-to-back high then low nibble to the same byte
        c = cyc;
        exp_wr(12'h123, 8'hC3, c + 4);
        exp_wr(12'h123, 8'hC4, c + 7);
        cpu_set(13'h1123, 4'hC);
        nclk(1); cpu_clr();
        nclk(1); cpu_set(13'h0123, 4'h4);
        nclk(1); cpu_clr();
        nclk(10);
        check("t2_ram", 32'(mem[12'h123]), 32'h0C4);
        check("t2_ovf", 32'(ovf), 32'd0);

        // Video request during CAP preempts the RMW
        c = cyc;
        exp_wr(12'h300, 8'h59, c + 7);
        exp_vid(4'hE, c + 6);
        cpu_set(13'h0300, 4'h9);
        nclk(1); cpu_clr();
        nclk(2);
        vid_addr = 12'h200; vid_lo = 1'b1; vid_req = 1'b1;
        nclk(1); vid_req = 1'b0;
        nclk(10);
        check("t3_ram", 32'(mem[12'h300]), 32'h059);

        // Video request during WR is deferred one cycle
        c = cyc;
        exp_wr(12'h400, 8'h62, c + 4);
        exp_vid(4'hB, c + 8);
        cpu_set(13'h1400, 4'h6);
        nclk(1); cpu_clr();
        nclk(3);
        vid_addr = 12'h201; vid_lo = 1'b0; vid_req = 1'b1;
        nclk(1); vid_req = 1'b0;
        nclk(10);
        check("t4_ram", 32'(mem[12'h400]), 32'h062);

        // Overflow: continuous video starves the RMW while 5 writes arrive
        vid_addr = 12'h200; vid_lo = 1'b1; vid_req = 1'b1;
        exp_vid(4'hE, cyc + 3);
        nclk(1);
        for (int i = 0; i < 5; i++) begin
            exp_vid(4'hE, cyc + 3);
            cpu_set(13'(13'h0500 + i), 4'(i + 1));
            nclk(1);
            exp_vid(4'hE, cyc + 3);
            cpu_clr();
            if (i == 2) check("t5_wait_after3", 32'(cpu_wait), 32'd0);
            if (i == 3) begin
                check("t5_wait_after4", 32'(cpu_wait), 32'd1);
                check("t5_ovf_after4",  32'(ovf),      32'd0);
            end
            if (i == 4) begin
                check("t5_wait_after5", 32'(cpu_wait), 32'd1);
                check("t5_ovf_after5",  32'(ovf),      32'd1);
            end
            nclk(1);
        end
        vid_req = 1'b0;
        for (int i = 0; i < 4; i++) exp_wr(12'(12'h500 + i), 8'(8'hF1 + i), -1);
        nclk(25);
        for (int i = 0; i < 4; i++) check("t5_ram", 32'(mem[12'h500 + i]), 32'(8'hF1 + i));
        check("t5_dropped", 32'(mem[12'h504]), 32'h0F0);
        check("t5_wait_drained", 32'(cpu_wait), 32'd0);
        check("t5_ovf_sticky",   32'(ovf),      32'd1);

        // Reset while in WR aborts the write
        cpu_set(13'h0600, 4'h7);
        nclk(1); cpu_clr();
        nclk(2);
        @(posedge clk); #2;
        check("t6_in_wr", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_we",    32'(ram_we),    32'd0);
        check("t6_rst_wait",  32'(cpu_wait),  32'd0);
        check("t6_rst_ovf",   32'(ovf),       32'd0);
        check("t6_rst_addr",  32'(ram_addr),  32'd0);
        check("t6_rst_valid", 32'(vid_valid), 32'd0);
        nclk(2);
        rst_n = 1'b1;
        nclk(15);
        check("t6_ram", 32'(mem[12'h600]), 32'h088);

        check("wr_q_drained",  wr_q.size(),  0);
        check("vid_q_drained", vid_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
